// File: rtl/prog_load_ctrl_if.sv
// Byte stream from the UART receiver plus the instruction-memory write port of the loader.
// Master is the loader (consumes bytes, drives writes); slave is the surrounding system.
interface prog_load_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              rx_dv;
  logic [7:0]        rx_byte;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    input  rx_dv,
    input  rx_byte,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output rx_dv,
    output rx_byte,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/prog_load_ctrl.sv
// Framed program download (LEN_LO, LEN_HI, 4*N payload bytes, CHK) into instruction memory.
// One memory write the cycle after each word's 4th byte; no backpressure, the byte stream is never stalled.
module prog_load_ctrl #(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  prog_load_ctrl_if.master  bus,
  output logic              cpu_halt,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);
  localparam int              TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0]     MAX_WORDS = 17'(2 ** ADDR_W);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [ADDR_W:0] WL_ONE    = (ADDR_W + 1)'(1);
  localparam logic [1:0]      ERR_NONE  = 2'd0;
  localparam logic [1:0]      ERR_LEN   = 2'd1;
  localparam logic [1:0]      ERR_CHK   = 2'd2;
  localparam logic [1:0]      ERR_TMO   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        err_nxt;
  logic [7:0]        len_lo;
  logic [15:0]       len;
  logic [15:0]       word_cnt;
  logic [1:0]        byte_cnt;
  logic [7:0]        sum;
  logic [23:0]       wbuf;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;

  logic [15:0]       len_n;
  logic              tmo_run;
  logic              tmo_hit;
  logic              last_word;
  logic              word_wr;

  assign len_n     = {bus.rx_byte, len_lo};
  assign tmo_run   = (state == S_LEN_HI) || (state == S_DATA) || (state == S_CHECK);
  assign tmo_hit   = tmo_run && !bus.rx_dv && (tmo_cnt == TMO_LAST);
  assign last_word = (word_cnt + 16'd1) == len;
  assign word_wr   = !start && (state == S_DATA) && bus.rx_dv && (byte_cnt == 2'd3);

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = err_code;
    busy      = (state == S_LEN_LO) || tmo_run;
    cpu_halt  = busy || (state == S_ERROR);
    done      = (state == S_DONE);
    // start outranks everything, including a byte arriving in the same cycle
    if (start) begin
      state_nxt = S_LEN_LO;
      err_nxt   = ERR_NONE;
    end else if (tmo_hit) begin
      state_nxt = S_ERROR;
      err_nxt   = ERR_TMO;
    end else if (bus.rx_dv) begin
      case (state)
        S_LEN_LO: state_nxt = S_LEN_HI;
        S_LEN_HI: begin
          if (len_n == 16'd0) begin
            state_nxt = S_CHECK;
          end else if ({1'b0, len_n} > MAX_WORDS) begin
            state_nxt = S_ERROR;
            err_nxt   = ERR_LEN;
          end else begin
            state_nxt = S_DATA;
          end
        end
        S_DATA: if (byte_cnt == 2'd3 && last_word) state_nxt = S_CHECK;
        S_CHECK: begin
          if (bus.rx_byte == sum) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_ERROR;
            err_nxt   = ERR_CHK;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_code     <= ERR_NONE;
      words_loaded <= '0;
      len_lo       <= '0;
      len          <= '0;
      word_cnt     <= '0;
      byte_cnt     <= '0;
      sum          <= '0;
      wbuf         <= '0;
      tmo_cnt      <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      err_code <= err_nxt;
      mem_we_q <= word_wr;
      if (start) begin
        words_loaded <= '0;
        len_lo       <= '0;
        len          <= '0;
        word_cnt     <= '0;
        byte_cnt     <= '0;
        sum          <= '0;
        wbuf         <= '0;
        tmo_cnt      <= '0;
      end else begin
        tmo_cnt <= (tmo_run && !bus.rx_dv) ? tmo_cnt + TMO_ONE : '0;
        if (state == S_LEN_LO && bus.rx_dv) len_lo <= bus.rx_byte;
        if (state == S_LEN_HI && bus.rx_dv) len    <= len_n;
        if (state == S_DATA && bus.rx_dv) begin
          byte_cnt <= byte_cnt + 2'd1;
          sum      <= sum + bus.rx_byte;
          case (byte_cnt)
            2'd0:    wbuf[7:0]   <= bus.rx_byte;
            2'd1:    wbuf[15:8]  <= bus.rx_byte;
            2'd2:    wbuf[23:16] <= bus.rx_byte;
            default: wbuf        <= wbuf;
          endcase
        end
        // address and data hold between writes; earlier words stay written on error
        if (word_wr) begin
          mem_addr_q   <= word_cnt[ADDR_W-1:0];
          mem_wdata_q  <= {bus.rx_byte, wbuf};
          word_cnt     <= word_cnt + 16'd1;
          words_loaded <= words_loaded + WL_ONE;
        end
      end
    end
  end
endmodule

// File: tb/tb_prog_load_ctrl.sv
// Bench for prog_load_ctrl: directed frames plus randomized frames against a frame-level model.
module tb_prog_load_ctrl;
  localparam int ADDR_W = 10;
  localparam int TMO    = 50;
  localparam int MAXN   = 1 << ADDR_W;

  typedef logic [7:0] bq_t[$];

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            cpu_halt, busy, done;
  logic [1:0]      err_code;
  logic [ADDR_W:0] words_loaded;
  int              n_tests = 0;
  int              n_fail = 0;
  int              we_count = 0;

  prog_load_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  prog_load_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .cpu_halt(cpu_halt), .busy(busy), .done(done),
    .err_code(err_code), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (bus.mem_we === 1'b1) we_count++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_dv   = 1'b1;
    bus.rx_byte = b;
    tick();
    bus.rx_dv   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, ".we"},    bus.mem_we, 0);
    check_val({tag, ".addr"},  bus.mem_addr, 0);
    check_val({tag, ".wdata"}, bus.mem_wdata, 0);
    check_val({tag, ".halt"},  cpu_halt, 0);
    check_val({tag, ".busy"},  busy, 0);
    check_val({tag, ".done"},  done, 0);
    check_val({tag, ".err"},   err_code, 0);
    check_val({tag, ".wl"},    words_loaded, 0);
  endtask

  // Frame-level model: header gives N, payload words are little-endian groups of four,
  // checksum is the 8-bit sum of payload bytes; an oversize N ends the frame after the header.
  task automatic run_frame(input bq_t q, input bit do_start, input int max_gap, input string tag);
    int          n;
    bit          len_bad;
    bit          wflag;
    logic [7:0]  psum;
    logic [31:0] w;
    int          exp_words;
    if (do_start) begin
      pulse_start();
      check_val({tag, ".start_busy"}, busy, 1);
      check_val({tag, ".start_halt"}, cpu_halt, 1);
      check_val({tag, ".start_wl"},   words_loaded, 0);
    end
    we_count = 0;
    n        = {q[1], q[0]};
    len_bad  = (n > MAXN);
    psum     = 8'd0;
    if (!len_bad)
      for (int k = 0; k < 4 * n; k++) psum = psum + q[2 + k];
    for (int j = 0; j < q.size(); j++) begin
      send_byte(q[j]);
      wflag = !len_bad && (j >= 2) && (j < 2 + 4 * n) && ((j - 2) % 4 == 3);
      check_val({tag, ".we"}, bus.mem_we, wflag);
      if (wflag) begin
        w = {q[j], q[j-1], q[j-2], q[j-3]};
        check_val({tag, ".addr"},  bus.mem_addr, (j - 2) / 4);
        check_val({tag, ".wdata"}, bus.mem_wdata, w);
        check_val({tag, ".wl_inc"}, words_loaded, (j - 2) / 4 + 1);
      end
      if (j == 1 && len_bad) check_val({tag, ".len_err"}, err_code, 1);
      idle($urandom_range(0, max_gap));
    end
    idle(2);
    exp_words = len_bad ? 0 : n;
    check_val({tag, ".wl"},   words_loaded, exp_words);
    check_val({tag, ".nwr"},  we_count, exp_words);
    check_val({tag, ".busy"}, busy, 0);
    if (len_bad) begin
      check_val({tag, ".err"},  err_code, 1);
      check_val({tag, ".done"}, done, 0);
      check_val({tag, ".halt"}, cpu_halt, 1);
    end else if (q[2 + 4 * n] == psum) begin
      check_val({tag, ".err"},  err_code, 0);
      check_val({tag, ".done"}, done, 1);
      check_val({tag, ".halt"}, cpu_halt, 0);
    end else begin
      check_val({tag, ".err"},  err_code, 2);
      check_val({tag, ".done"}, done, 0);
      check_val({tag, ".halt"}, cpu_halt, 1);
    end
  endtask

  initial begin
    bq_t  t1, q;
    int   n;
    logic [7:0] s;
    bus.rx_dv   = 1'b0;
    bus.rx_byte = 8'h00;
    t1 = {8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'hB8};

    idle(3);
    check_zero_outputs("rst_hold");
    rst = 1'b0;
    tick();
    send_byte(8'h02);
    check_val("idle_ignore.busy", busy, 0);
    check_val("idle_ignore.we", bus.mem_we, 0);

    run_frame(t1, 1, 0, "t1");
    send_byte(8'hAB);
    check_val("done_ignore.we", bus.mem_we, 0);
    check_val("done_ignore.done", done, 1);

    q = t1; q[10] = 8'hB9;
    run_frame(q, 1, 2, "t2");
    run_frame({8'h00, 8'h00, 8'h00}, 1, 0, "t3a");
    run_frame({8'h00, 8'h00, 8'h01}, 1, 0, "t3b");
    run_frame({8'h01, 8'h04}, 1, 0, "t4");

    // largest legal frame
    q = {8'h00, 8'h04};
    s = 8'd0;
    for (int k = 0; k < 4 * MAXN; k++) begin
      q.push_back(8'($urandom_range(0, 255)));
      s = s + q[q.size() - 1];
    end
    q.push_back(s);
    run_frame(q, 1, 0, "nmax");

    // no timeout while waiting for the first header byte
    pulse_start();
    idle(3 * TMO);
    check_val("lenlo_wait.busy", busy, 1);
    check_val("lenlo_wait.err", err_code, 0);
    run_frame(t1, 0, 0, "lenlo_wait");

    // inter-byte timeout
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h44);
    for (int k = 1; k <= TMO; k++) begin
      tick();
      if (k == TMO - 1) begin
        check_val("tmo_pre.err", err_code, 0);
        check_val("tmo_pre.busy", busy, 1);
      end
    end
    check_val("tmo.err", err_code, 3);
    check_val("tmo.busy", busy, 0);
    check_val("tmo.halt", cpu_halt, 1);
    run_frame(t1, 1, 0, "tmo_rerun");

    // start with a simultaneous byte: the byte must be discarded
    start = 1'b1; bus.rx_dv = 1'b1; bus.rx_byte = 8'h05;
    tick();
    start = 1'b0; bus.rx_dv = 1'b0;
    run_frame({8'h01, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA0}, 0, 1, "start_dv");

    // restart in mid-frame
    pulse_start();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h44); send_byte(8'h33);
    run_frame(t1, 1, 0, "abort");

    // reset in mid-frame
    pulse_start();
    for (int k = 0; k < 8; k++) send_byte(t1[k]);
    #1 rst = 1'b1;
    #1 check_zero_outputs("rst_mid");
    tick();
    rst = 1'b0;
    for (int k = 8; k < 11; k++) send_byte(t1[k]);
    check_zero_outputs("rst_after");
    run_frame(t1, 1, 0, "rst_rerun");

    for (int r = 0; r < 25; r++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 9) begin
        n = $urandom_range(MAXN + 1, 65535);
        q = {n[7:0], n[15:8], 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      end else begin
        n = $urandom_range(0, 5);
        q = {n[7:0], n[15:8]};
        s = 8'd0;
        for (int k = 0; k < 4 * n; k++) begin
          q.push_back(8'($urandom_range(0, 255)));
          s = s + q[q.size() - 1];
        end
        if (kind >= 7) s = s + 8'($urandom_range(1, 255));
        q.push_back(s);
      end
      run_frame(q, 1, 3, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
